// File: rtl/seq_det_pkg.sv
// Shared types and default configuration for the serial pattern-detection controller.
package seq_det_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Power-on configuration: the classic "101" overlapping detector.
  localparam int unsigned DEF_PATTERN = 5;
  localparam int unsigned DEF_LEN     = 3;
  localparam logic        DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial history register with fill tracking and masked pattern compare.
// hit is combinational: it reflects the bit currently being shifted in.
module seq_det_core #(
  parameter int MAXLEN = 8,
  parameter int LEN_W  = $clog2(MAXLEN) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              in_bit,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [LEN_W-1:0]  len,
  input  logic              overlap,
  output logic              hit
);

  logic [MAXLEN-1:0] hist_q, hist_d, hist_next, mask;
  logic [LEN_W-1:0]  fill_q, fill_d, fill_inc;

  // Build the compare mask and the candidate history/fill for this cycle.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    hist_next = {hist_q[MAXLEN-2:0], in_bit};
    fill_inc  = (fill_q == LEN_W'(MAXLEN)) ? fill_q : fill_q + 1'b1;
    hit       = shift_en && (fill_inc >= len) && (((hist_next ^ pattern) & mask) == '0);
  end

  // History update: explicit clear wins, then non-overlap clear on a hit, else shift.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      if (hit && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_next;
        fill_d = fill_inc;
      end
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller: config registers, IDLE/RUN/DONE sequencing, match and timeout counters.
// Handshake: start/stop/cfg_we are single-cycle level requests sampled on the rising
// edge; in_bit is consumed on every edge where in_valid=1 while in RUN (no backpressure).
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8,
  parameter int TO_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [MAXLEN-1:0]        cfg_pattern,
  input  logic [$clog2(MAXLEN):0]  cfg_len,
  input  logic                     cfg_overlap,
  input  logic [CNT_W-1:0]         cfg_target,
  input  logic [TO_W-1:0]          cfg_timeout,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic                     match,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic                     cfg_err,
  output state_t                   dbg_state
);

  localparam int LEN_W = $clog2(MAXLEN) + 1;

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovl_q, ovl_d;
  logic [CNT_W-1:0]  tgt_q, tgt_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic              cfg_err_q, cfg_err_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic              in_run, start_ok, cfg_legal, hit, target_hit, to_expire;
  logic [CNT_W-1:0]  cnt_inc;
  logic [TO_W-1:0]   to_inc;

  // Shared decode of requests and terminal conditions.
  always_comb begin
    in_run     = (state_q == RUN);
    start_ok   = !in_run && start && !cfg_we && !cfg_err_q;
    cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAXLEN));
    cnt_inc    = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + 1'b1;
    to_inc     = to_cnt_q + 1'b1;
    target_hit = hit && (tgt_q != '0) && (cnt_inc == tgt_q);
    to_expire  = (tmo_q != '0) && (to_inc == tmo_q);
  end

  seq_det_core #(.MAXLEN(MAXLEN), .LEN_W(LEN_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .shift_en (in_run && in_valid),
    .in_bit   (in_bit),
    .pattern  (pat_q),
    .len      (len_q),
    .overlap  (ovl_q),
    .hit      (hit)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: stop and target beat timeout; a match suppresses timeout expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (cfg_we)        state_d = IDLE;
        else if (start_ok) state_d = RUN;
      end
      RUN: begin
        if (stop || target_hit)    state_d = DONE;
        else if (!hit && to_expire) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registered outputs: match pulse, done and timeout flags.
  always_comb begin
    match_d   = hit;
    done_d    = done_q;
    timeout_d = timeout_q;
    if (!in_run && (cfg_we || start_ok)) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end
    if (in_run) begin
      if (stop || target_hit) begin
        done_d    = 1'b1;
        timeout_d = 1'b0;
      end else if (!hit && to_expire) begin
        done_d    = 1'b1;
        timeout_d = 1'b1;
      end
    end
  end

  // Config loading and run counters.
  always_comb begin
    pat_d       = pat_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    tgt_d       = tgt_q;
    tmo_d       = tmo_q;
    cfg_err_d   = cfg_err_q;
    match_cnt_d = match_cnt_q;
    to_cnt_d    = to_cnt_q;
    if (!in_run && cfg_we) begin
      if (cfg_legal) begin
        pat_d     = cfg_pattern;
        len_d     = cfg_len;
        ovl_d     = cfg_overlap;
        tgt_d     = cfg_target;
        tmo_d     = cfg_timeout;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
    if (start_ok) begin
      match_cnt_d = '0;
      to_cnt_d    = '0;
    end
    if (in_run) begin
      to_cnt_d = hit ? '0 : to_inc;
      if (hit) match_cnt_d = cnt_inc;
    end
  end

  // Config, flag and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q       <= MAXLEN'(DEF_PATTERN);
      len_q       <= LEN_W'(DEF_LEN);
      ovl_q       <= DEF_OVERLAP;
      tgt_q       <= '0;
      tmo_q       <= '0;
      cfg_err_q   <= 1'b0;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      tgt_q       <= tgt_d;
      tmo_q       <= tmo_d;
      cfg_err_q   <= cfg_err_d;
      match_q     <= match_d;
      match_cnt_q <= match_cnt_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = match_cnt_q;
  assign busy      = in_run;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: one task per scenario with hand-computed expectations.
module tb_seq_det_ctrl;
  import seq_det_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic [7:0]  cfg_target = '0;
  logic [15:0] cfg_timeout = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        match;
  logic [7:0]  match_cnt;
  logic        busy, done, timeout, cfg_err;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;

  seq_det_ctrl #(.MAXLEN(8), .CNT_W(8), .TO_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .cfg_timeout(cfg_timeout), .start(start), .stop(stop), .in_valid(in_valid),
    .in_bit(in_bit), .match(match), .match_cnt(match_cnt), .busy(busy),
    .done(done), .timeout(timeout), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    step();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic [7:0] t, input logic [15:0] to);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_timeout = to;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    total++;
    if ({match, match_cnt, busy, done, timeout, cfg_err} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h exp=0", {match, match_cnt, busy, done, timeout, cfg_err});
    end
    total++;
    if (dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_default_overlap();
    logic [4:0] bits, exp;
    bits = 5'b10101;
    exp  = 5'b00101;
    do_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL def_busy_after_start got=%0b exp=1", busy); end
    for (int i = 4; i >= 0; i--) begin
      send_bit(bits[i]);
      total++;
      if (match !== exp[i]) begin bad++; $display("FAIL def_match_bit%0d got=%0b exp=%0b", 5 - i, match, exp[i]); end
    end
    total++;
    if (match_cnt !== 8'd2) begin bad++; $display("FAIL def_match_cnt got=%0d exp=2", match_cnt); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL def_busy_end got=%0b exp=1", busy); end
    do_stop();
    total++;
    if ({done, timeout, busy} !== 3'b100) begin bad++; $display("FAIL def_stop got=%0b exp=100", {done, timeout, busy}); end
  endtask

  task automatic test_non_overlap();
    logic [7:0] bits, exp;
    bits = 8'b10101101;
    exp  = 8'b00100001;
    do_cfg(8'b101, 4'd3, 1'b0, 8'd0, 16'd0);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL novl_cfg_clears_done got=%0b exp=0", done); end
    do_start();
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i]);
      total++;
      if (match !== exp[i]) begin bad++; $display("FAIL novl_match_bit%0d got=%0b exp=%0b", 8 - i, match, exp[i]); end
    end
    total++;
    if (match_cnt !== 8'd2) begin bad++; $display("FAIL novl_match_cnt got=%0d exp=2", match_cnt); end
    do_stop();
  endtask

  task automatic test_target();
    logic [11:0] bits, exp;
    bits = 12'b110011001100;
    exp  = 12'b000100010000;
    do_cfg(8'b1100, 4'd4, 1'b1, 8'd2, 16'd0);
    do_start();
    for (int i = 11; i >= 0; i--) begin
      send_bit(bits[i]);
      total++;
      if (match !== exp[i]) begin bad++; $display("FAIL tgt_match_bit%0d got=%0b exp=%0b", 12 - i, match, exp[i]); end
      if (i == 8) begin
        total++;
        if ({done, busy} !== 2'b01) begin bad++; $display("FAIL tgt_first_hit got=%0b exp=01", {done, busy}); end
      end
      if (i == 4) begin
        total++;
        if ({done, busy, timeout} !== 3'b100) begin bad++; $display("FAIL tgt_reached got=%0b exp=100", {done, busy, timeout}); end
      end
    end
    total++;
    if (match_cnt !== 8'd2) begin bad++; $display("FAIL tgt_match_cnt got=%0d exp=2", match_cnt); end
  endtask

  task automatic test_timeout();
    do_cfg(8'b101, 4'd3, 1'b1, 8'd0, 16'd5);
    do_start();
    for (int c = 1; c <= 5; c++) begin
      step();
      total++;
      if (done !== (c == 5)) begin bad++; $display("FAIL to_idle_cycle%0d done got=%0b exp=%0b", c, done, c == 5); end
    end
    total++;
    if ({timeout, busy, match_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      bad++; $display("FAIL to_expired got=%0h exp=200", {timeout, busy, match_cnt});
    end
    // A match on cycle 4 restarts the count: expiry moves to cycle 9.
    do_start();
    step();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    total++;
    if (match !== 1'b1) begin bad++; $display("FAIL to_restart_match got=%0b exp=1", match); end
    for (int c = 5; c <= 9; c++) begin
      step();
      total++;
      if (done !== (c == 9)) begin bad++; $display("FAIL to_restart_cycle%0d done got=%0b exp=%0b", c, done, c == 9); end
    end
    total++;
    if ({timeout, match_cnt} !== {1'b1, 8'd1}) begin bad++; $display("FAIL to_restart_end got=%0h exp=101", {timeout, match_cnt}); end
    // Match landing on the expiry cycle wins and keeps the run going.
    do_start();
    step();
    step();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    total++;
    if ({match, busy, done} !== 3'b110) begin bad++; $display("FAIL to_match_wins got=%0b exp=110", {match, busy, done}); end
    do_stop();
    total++;
    if ({done, timeout} !== 2'b10) begin bad++; $display("FAIL to_stop_after got=%0b exp=10", {done, timeout}); end
  endtask

  task automatic test_cfg_err();
    do_cfg(8'hff, 4'd0, 1'b0, 8'd3, 16'd0);
    total++;
    if ({cfg_err, done} !== 2'b10) begin bad++; $display("FAIL err_len0 got=%0b exp=10", {cfg_err, done}); end
    do_start();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL err_start_blocked got=%0b exp=0", busy); end
    do_cfg(8'hff, 4'd9, 1'b0, 8'd3, 16'd0);
    total++;
    if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_len9 got=%0b exp=1", cfg_err); end
    do_cfg(8'b101, 4'd3, 1'b1, 8'd0, 16'd0);
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%0b exp=0", cfg_err); end
    cfg_we = 1'b1;
    start  = 1'b1;
    step();
    cfg_we = 1'b0;
    start  = 1'b0;
    total++;
    if ({busy, cfg_err} !== 2'b00) begin bad++; $display("FAIL err_cfg_with_start got=%0b exp=00", {busy, cfg_err}); end
  endtask

  task automatic test_stop_with_match();
    do_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy got=%0b exp=1", busy); end
    send_bit(1'b1);
    step();
    send_bit(1'b0);
    step();
    in_valid = 1'b1;
    in_bit   = 1'b1;
    stop     = 1'b1;
    step();
    in_valid = 1'b0;
    in_bit   = 1'b0;
    stop     = 1'b0;
    total++;
    if ({match, match_cnt, done, timeout, busy} !== {1'b1, 8'd1, 3'b100}) begin
      bad++; $display("FAIL stop_match got=%0h exp=%0h", {match, match_cnt, done, timeout, busy}, {1'b1, 8'd1, 3'b100});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [2:0] bits, exp;
    bits = 3'b101;
    exp  = 3'b001;
    do_cfg(8'b0110, 4'd4, 1'b1, 8'd0, 16'd0);
    do_start();
    send_bit(1'b1);
    total++;
    if ({busy, done, match_cnt} !== {2'b10, 8'd0}) begin bad++; $display("FAIL rst_pre_run got=%0h exp=200", {busy, done, match_cnt}); end
    reset = 1'b0;
    #2;
    total++;
    if ({match, match_cnt, busy, done, timeout, cfg_err} !== 13'd0) begin
      bad++; $display("FAIL rst_mid_run got=%0h exp=0", {match, match_cnt, busy, done, timeout, cfg_err});
    end
    reset = 1'b1;
    step();
    do_start();
    for (int i = 2; i >= 0; i--) begin
      send_bit(bits[i]);
      total++;
      if (match !== exp[i]) begin bad++; $display("FAIL rst_default_cfg_bit%0d got=%0b exp=%0b", 3 - i, match, exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_non_overlap();
    test_target();
    test_timeout();
    test_cfg_err();
    test_stop_with_match();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable serial pattern-detection controller. It holds a run-time pattern configuration (up to MAXLEN bits, overlapping or non-overlapping), arms on `start`, and counts matches on a bit-serial stream. It terminates on a target count, an inactivity timeout or `stop`. It sits between the register/config side and the serial input, and generalises the fixed 101 Moore detector into a sequenced, reconfigurable resource.

## Interface
- MAXLEN, 8, maximum pattern length in bits
- CNT_W, 8, width of match counter and target
- TO_W, 16, width of timeout counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  load configuration (accepted in IDLE/DONE only)
- cfg_pattern  in  MAXLEN  pattern; bit [cfg_len-1] is received first, bit 0 last
- cfg_len  in  $clog2(MAXLEN)+1  pattern length, legal 1..MAXLEN
- cfg_overlap  in  1  1 = overlapping detection, 0 = history cleared after each match
- cfg_target  in  CNT_W  matches to finish a run; 0 = unlimited
- cfg_timeout  in  TO_W  max RUN cycles without a match; 0 = disabled
- start  in  1  begin a run
- stop  in  1  abort a run
- in_valid  in  1  in_bit qualifier
- in_bit  in  1  serial data
- match  out  1  one-cycle match pulse
- match_cnt  out  CNT_W  matches in current run, saturating
- busy  out  1  high in RUN
- done  out  1  run finished; held until next accepted start/cfg_we
- timeout  out  1  run ended by timeout; held with done
- cfg_err  out  1  last cfg_we was illegal; held until next cfg_we

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start when cfg_err=0. Starting clears match_cnt, history, fill count, timeout counter, done and timeout.
- RUN -> DONE when one of these occurs:
  - a match makes match_cnt == cfg_target (target != 0);
  - the timeout counter reaches cfg_timeout (non-zero);
  - stop is asserted.
- DONE -> RUN on start under the same conditions as from IDLE. DONE -> IDLE on cfg_we.
- Start is ignored in RUN. Stop is ignored outside RUN.
- Config registers reset to: pattern 3'b101, len 3, overlap 1, target 0, timeout 0.
- cfg_we with len 0 or len > MAXLEN: cfg_err=1 and the config is unchanged. A legal cfg_we sets cfg_err=0. cfg_we in RUN is ignored entirely.
- Detection: each in_valid bit shifts into a MAXLEN history register, and fill increments, saturating at MAXLEN.
  - Match = fill ≥ len and the low len bits of the history equal the low len bits of the pattern.
  - Bits with in_valid=0 are not shifted and are not counted by fill.
- On a match with overlap=0, history and fill clear. With overlap=1, they are retained.
- The timeout counter counts clock cycles in RUN. It is cleared on entry to RUN and on every match.
- match_cnt saturates at 2^CNT_W-1. A saturated count with target 0 keeps the run going.

## Timing
- Reset (async assert, sync deassert by the system): state IDLE, all outputs 0, config at defaults.
- Reset mid-run aborts immediately, with no done.
- match is registered (Moore). It is high for exactly the cycle after the edge that sampled the completing bit. match_cnt updates on the same edge.
- Target reached: match=1, done=1 and busy=0 in the same cycle.
- Simultaneous events:
  - match + stop: the match is counted, then DONE with timeout=0.
  - match + timeout expiry: the match wins, the counter clears, and the FSM stays in RUN unless the target is reached.
  - stop + timeout: stop wins, timeout=0.
  - cfg_we + start: config loads and start is ignored.
- Bits presented in IDLE or DONE are ignored.

## Structure
- Package seq_det_pkg holds the state enum (IDLE, RUN, DONE) and the default-config constants (DEF_PATTERN, DEF_LEN, DEF_OVERLAP).
- Sub-module seq_det_core holds the history shift register, fill counter, masked compare and overlap clear. It takes a clear input and produces a combinational hit signal.
- The controller FSM, config registers and counters are in seq_det_ctrl.

## Test plan
- Defaults after reset, start, bits 1,0,1,0,1 on consecutive cycles -> match after the 3rd and 5th bits, match_cnt=2, busy=1.
- cfg 101/len 3/overlap 0, bits 1,0,1,0,1,1,0,1 -> matches after the 3rd and 8th bits only, match_cnt=2.
- cfg 4'b1100/len 4/overlap 1/target 2, bits 1,1,0,0,1,1,0,0,1,1,0,0 -> match pulses at bits 4 and 8. done=1 and busy=0 arrive with the second pulse, and later bits produce no match.
- timeout=5, target 0, bits all 0 -> done=1, timeout=1 five cycles after entering RUN, match_cnt=0. A match on cycle 4 instead restarts the timeout count.
- cfg_we len=0 -> cfg_err=1 and the config is unchanged. A following start is ignored (busy stays 0). A legal cfg_we clears cfg_err.
- Bits 1,0,1 with in_valid low between each bit, stop asserted with the completing bit -> match counted (match_cnt=1), done=1, timeout=0. Reset during a later run -> all outputs 0, config back to 101/len 3.
